warp_scheduler: RTL
===================

Name: warp_scheduler

Overview:
- Per-core sequencer that steps one block of threads through the instruction cycle: FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE.
- Broadcasts core_state to the fetcher, decoder, ALUs, LSUs and PC units.
- Gates WAIT on per-thread LSU status, advances the shared PC from thread 0 and flags divergence among active threads.
- Asserts done after a RET instruction.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes (ALU/LSU/PC units) in the core
PC_BITS, 8, program counter width

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high; all state is cleared on the clk edge where reset=1
start  input  1  launch pulse from dispatcher; honoured only in IDLE
thread_count  input  $clog2(THREADS_PER_BLOCK)+1  active lanes; sampled on accepted start
decoded_mem_read_enable  input  1  current instruction is LDR
decoded_mem_write_enable  input  1  current instruction is STR
decoded_done  input  1  current instruction is RET
fetcher_state  input  3  fetcher FSM; FETCHED=3'b010
lsu_state  input  2*THREADS_PER_BLOCK  per-lane LSU state (lane i at [2i+1:2i]); IDLE=00, REQUESTING=01, WAITING=10, DONE=11
next_pc  input  PC_BITS*THREADS_PER_BLOCK  per-lane computed next PC (lane i at [PC_BITS*(i+1)-1:PC_BITS*i])
current_pc  output  PC_BITS  shared PC driven to the fetcher
core_state  output  3  IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111
done  output  1  block finished; held high until reset
divergence  output  1  sticky flag: an active lane disagreed with lane 0 on next_pc

Behaviour:
- Reset values: core_state=IDLE, current_pc=0, done=0, divergence=0, internal active count=0. Reset overrides every transition, including mid-instruction.
- IDLE:
  - start=1 with thread_count>0 latches thread_count and moves to FETCH next cycle.
  - start=1 with thread_count=0 moves to DONE; done=1 on that same edge.
  - start=0 stays in IDLE.
- start in any state other than IDLE is ignored.
- FETCH: stays until fetcher_state==FETCHED, then goes to DECODE. There is no timeout.
- DECODE: goes to REQUEST after exactly 1 cycle. Decoder outputs are valid from this state onward.
- REQUEST: goes to WAIT after exactly 1 cycle. LSUs leave IDLE during this cycle.
- WAIT, for active lanes i < latched count:
  - Exit to EXECUTE when no active lane is in REQUESTING or WAITING.
  - If decoded_mem_read_enable or decoded_mem_write_enable is set, exit additionally requires every active lane to be in DONE. This blocks an early exit while an LSU is still IDLE.
  - Inactive lanes are ignored entirely.
- EXECUTE: goes to UPDATE after exactly 1 cycle.
- UPDATE:
  - decoded_done=1: go to DONE, done=1 on the same edge, current_pc unchanged.
  - Otherwise: current_pc <= lane 0 next_pc, then go to FETCH.
  - Divergence check: if any active lane i>0 has next_pc != lane 0's, set divergence=1. The flag stays set until reset and does not alter sequencing.
- DONE: holds. done stays 1 and current_pc is frozen. Only reset leaves DONE.
- PC arithmetic: current_pc takes next_pc verbatim; wrap-around (0xFF to 0x00) is the PC unit's concern and is not detected here.
- Minimum latency is 6 cycles per non-memory instruction (FETCH ready immediately), from FETCH entry to the next FETCH entry.
- Simultaneous reset and start: reset wins and the block stays in IDLE.

Decomposition:
- Shared package gpu_pkg:
  - core_state encodings (8 values above).
  - fetcher state FETCHED.
  - LSU state encodings.
  - opcode localparams, shared with the decoder.
- One natural sub-module, lsu_wait_check: a combinational reduction over the active-lane mask that produces wait_clear. Everything else lives in warp_scheduler.

Test Plan:
- Reset then start with thread_count=4; fetcher FETCHED immediately; non-memory instruction with next_pc all 0x01 -> core_state 001,010,011,100,101,110,001 on consecutive edges; current_pc=0x01 after UPDATE; divergence=0.
- LDR with all 4 lanes: LSUs go REQUESTING for 1 cycle, WAITING for 5, then DONE -> scheduler stays in WAIT until the edge after the last lane reaches DONE, then enters EXECUTE.
- thread_count=2; lanes 2,3 hold lsu_state=IDLE during an STR; lane 3 next_pc=0x07 vs lane 0 0x05 -> WAIT exits once lanes 0,1 are DONE; current_pc=0x05; divergence stays 0.
- thread_count=4; lane 2 next_pc=0x09 vs lane 0 0x04 -> current_pc=0x04; divergence=1 and remains 1 for the rest of the run.
- decoded_done=1 in UPDATE with current_pc=0x0C -> core_state=111, done=1, current_pc stays 0x0C; a later start pulse produces no change.
- reset asserted in WAIT with done=0, then start with thread_count=0 -> after reset: IDLE, pc=0; after start: DONE, done=1 next edge.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core: scheduler states, fetcher/LSU handshakes
// and the opcode map used by the decoder.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_BRNZP = 4'b0001;
  localparam logic [3:0] OP_CMP   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_DIV   = 4'b0110;
  localparam logic [3:0] OP_LDR   = 4'b0111;
  localparam logic [3:0] OP_STR   = 4'b1000;
  localparam logic [3:0] OP_CONST = 4'b1001;
  localparam logic [3:0] OP_RET   = 4'b1111;

endpackage

// File: rtl/lsu_wait_check.sv
// Reduces per-lane LSU status over the active-lane mask into a single
// "WAIT may exit" flag; inactive lanes never hold the scheduler.
module lsu_wait_check
  import gpu_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic [2*THREADS-1:0] lsu_state_i,
  input  logic [THREADS-1:0]   active_mask_i,
  input  logic                 mem_op_i,
  output logic                 wait_clear_o
);

  always_comb begin
    wait_clear_o = 1'b1;
    for (int i = 0; i < THREADS; i++) begin
      if (active_mask_i[i]) begin
        if (lsu_state_i[2*i +: 2] == LSU_REQUESTING ||
            lsu_state_i[2*i +: 2] == LSU_WAITING)
          wait_clear_o = 1'b0;
        // A memory op must see DONE, so a lane still IDLE cannot slip through.
        if (mem_op_i && lsu_state_i[2*i +: 2] != LSU_DONE)
          wait_clear_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core instruction-cycle sequencer for one block of threads.
//   state   | meaning
//   IDLE    | waiting for a start from the dispatcher
//   FETCH   | fetcher reading the instruction at current_pc
//   DECODE  | decoder outputs settle
//   REQUEST | LSUs issue memory requests
//   WAIT    | hold until active lanes' LSUs are quiet
//   EXECUTE | ALUs compute
//   UPDATE  | shared PC advances from lane 0, divergence sampled
//   DONE    | block retired; held until reset
module warp_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
  input  logic                                   decoded_mem_read_enable,
  input  logic                                   decoded_mem_write_enable,
  input  logic                                   decoded_done,
  input  logic [2:0]                             fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
  output logic [PC_BITS-1:0]                     current_pc,
  output logic [2:0]                             core_state,
  output logic                                   done,
  output logic                                   divergence
);

  localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

  core_state_e                  state_q, state_d;
  logic        [PC_BITS-1:0]    pc_q, pc_d;
  logic        [CNT_W-1:0]      count_q, count_d;
  logic                         done_q, done_d;
  logic                         div_q, div_d;

  logic [THREADS_PER_BLOCK-1:0] active_mask;
  logic                         wait_clear;
  logic                         lane_diverge;

  always_comb begin
    active_mask = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++)
      active_mask[i] = (CNT_W'(i) < count_q);
  end

  always_comb begin
    lane_diverge = 1'b0;
    for (int i = 1; i < THREADS_PER_BLOCK; i++)
      if (active_mask[i] && (next_pc[PC_BITS*i +: PC_BITS] != next_pc[PC_BITS-1:0]))
        lane_diverge = 1'b1;
  end

  lsu_wait_check #(
    .THREADS (THREADS_PER_BLOCK)
  ) u_lsu_wait_check (
    .lsu_state_i   (lsu_state),
    .active_mask_i (active_mask),
    .mem_op_i      (decoded_mem_read_enable | decoded_mem_write_enable),
    .wait_clear_o  (wait_clear)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CORE_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      done_q  <= done_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    done_d  = done_q;
    div_d   = div_q;
    case (state_q)
      CORE_IDLE: begin
        if (start) begin
          if (thread_count != '0) begin
            count_d = thread_count;
            state_d = CORE_FETCH;
          end else begin
            state_d = CORE_DONE;
            done_d  = 1'b1;
          end
        end
      end
      CORE_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED)
          state_d = CORE_DECODE;
      end
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT: begin
        if (wait_clear)
          state_d = CORE_EXECUTE;
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        if (lane_diverge)
          div_d = 1'b1;
        if (decoded_done) begin
          state_d = CORE_DONE;
          done_d  = 1'b1;
        end else begin
          pc_d    = next_pc[PC_BITS-1:0];
          state_d = CORE_FETCH;
        end
      end
      CORE_DONE: state_d = CORE_DONE;
      default:   state_d = CORE_IDLE;
    endcase
  end

  assign current_pc = pc_q;
  assign core_state = state_q;
  assign done       = done_q;
  assign divergence = div_q;

endmodule
